// File: rtl/data_type_pkg.sv
// Shared types for the bfloat16 fpu issue front-end.
// Opcode enum, canonical qNaN and the response entry layout.
package data_type_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        MUL = 4'd2,
        DIV = 4'd3
    } fpu_op_e;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;

    typedef struct packed {
        logic [15:0] data;
        logic        dz;
        logic        ovf;
        logic        ill;
    } rsp_entry_t;

    function automatic logic is_illegal_op(input logic [3:0] op);
        return op > 4'(DIV);
    endfunction

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Synchronous response FIFO; pop-then-push is accepted when full.
// Head data reads as zero while empty.
module fpu_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign empty_o = (r_count == '0);
    assign full_o  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = pop_i && !empty_o;
    assign w_push  = push_i && (!full_o || w_pop);
    assign rdata_o = empty_o ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/response front-end around the combinational bf16 fpu.
// Optional sticky flag ports: define FPU_STICKY_FLAGS_EN.
module fpu_issue_ctrl
    import data_type_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
`ifdef FPU_STICKY_FLAGS_EN
    input  logic             clr_sticky_i,
    output logic             sticky_dz_o,
    output logic             sticky_ovf_o,
`endif
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [3:0]       req_op_i,
    input  logic [15:0]      req_in1_i,
    input  logic [15:0]      req_in2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic [3:0]       fpu_op_o,
    output logic [15:0]      fpu_in1_o,
    output logic [15:0]      fpu_in2_o,
    input  logic [15:0]      fpu_out_i,
    input  logic             fpu_div_zero_i,
    input  logic             fpu_overflow_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [15:0]      rsp_data_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_dz_o,
    output logic             rsp_ovf_o,
    output logic             rsp_ill_o
);

    localparam int EW = $bits(rsp_entry_t) + TAG_W;

    logic             r_e_valid;
    logic [3:0]       r_e_op;
    logic [15:0]      r_e_in1;
    logic [15:0]      r_e_in2;
    logic [TAG_W-1:0] r_e_tag;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_push;
    logic             w_accept;
    rsp_entry_t       w_entry;
    rsp_entry_t       w_head;
    logic [EW-1:0]    w_rdata;

    assign rsp_valid_o = !w_empty;
    assign w_pop       = rsp_valid_o && rsp_ready_i;
    assign w_push_ok   = !w_full || w_pop;
    assign w_push      = r_e_valid && w_push_ok;
    assign req_ready_o = !r_e_valid || w_push_ok;
    assign w_accept    = req_valid_i && req_ready_o;

    assign fpu_op_o  = r_e_valid ? r_e_op  : '0;
    assign fpu_in1_o = r_e_valid ? r_e_in1 : '0;
    assign fpu_in2_o = r_e_valid ? r_e_in2 : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_e_valid <= 1'b0;
            r_e_op    <= '0;
            r_e_in1   <= '0;
            r_e_in2   <= '0;
            r_e_tag   <= '0;
        end else if (w_accept) begin
            r_e_valid <= 1'b1;
            r_e_op    <= req_op_i;
            r_e_in1   <= req_in1_i;
            r_e_in2   <= req_in2_i;
            r_e_tag   <= req_tag_i;
        end else if (w_push) begin
            r_e_valid <= 1'b0;
        end
    end

    // Illegal opcodes never trust the fpu: canonical qNaN, ill only.
    always_comb begin
        w_entry = '{data: fpu_out_i, dz: fpu_div_zero_i,
                    ovf: fpu_overflow_i, ill: 1'b0};
        if (is_illegal_op(r_e_op)) begin
            w_entry = '{data: BF16_QNAN, dz: 1'b0,
                        ovf: 1'b0, ill: 1'b1};
        end
    end

    fpu_rsp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_push),
        .wdata_i ({w_entry, r_e_tag}),
        .pop_i   (rsp_ready_i),
        .rdata_o (w_rdata),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign {w_head, rsp_tag_o} = w_rdata;
    assign rsp_data_o = w_head.data;
    assign rsp_dz_o   = w_head.dz;
    assign rsp_ovf_o  = w_head.ovf;
    assign rsp_ill_o  = w_head.ill;

`ifdef FPU_STICKY_FLAGS_EN
    logic r_sticky_dz;
    logic r_sticky_ovf;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sticky_dz  <= 1'b0;
            r_sticky_ovf <= 1'b0;
        end else begin
            if (w_push && w_entry.dz)   r_sticky_dz <= 1'b1;
            else if (clr_sticky_i)      r_sticky_dz <= 1'b0;
            if (w_push && w_entry.ovf)  r_sticky_ovf <= 1'b1;
            else if (clr_sticky_i)      r_sticky_ovf <= 1'b0;
        end
    end

    assign sticky_dz_o  = r_sticky_dz;
    assign sticky_ovf_o = r_sticky_ovf;
`endif

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomized self-checking bench for fpu_issue_ctrl with a bf16 fpu stub.
// Sticky flag checks are built when FPU_STICKY_FLAGS_EN is defined.
module tb_fpu_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [3:0]       req_op = '0;
    logic [15:0]      req_in1 = '0;
    logic [15:0]      req_in2 = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [3:0]       fpu_op;
    logic [15:0]      fpu_in1;
    logic [15:0]      fpu_in2;
    logic [15:0]      fpu_out;
    logic             fpu_dz;
    logic             fpu_ovf;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [15:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_dz;
    logic             rsp_ovf;
    logic             rsp_ill;
`ifdef FPU_STICKY_FLAGS_EN
    logic             clr_sticky = 1'b0;
    logic             sticky_dz;
    logic             sticky_ovf;
`endif

    int n_checks = 0;
    int n_pass = 0;

    typedef struct packed {
        logic [15:0]      data;
        logic [TAG_W-1:0] tag;
        logic             dz;
        logic             ovf;
        logic             ill;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
`ifdef FPU_STICKY_FLAGS_EN
        .clr_sticky_i   (clr_sticky),
        .sticky_dz_o    (sticky_dz),
        .sticky_ovf_o   (sticky_ovf),
`endif
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_op_i       (req_op),
        .req_in1_i      (req_in1),
        .req_in2_i      (req_in2),
        .req_tag_i      (req_tag),
        .fpu_op_o       (fpu_op),
        .fpu_in1_o      (fpu_in1),
        .fpu_in2_o      (fpu_in2),
        .fpu_out_i      (fpu_out),
        .fpu_div_zero_i (fpu_dz),
        .fpu_overflow_i (fpu_ovf),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_data_o     (rsp_data),
        .rsp_tag_o      (rsp_tag),
        .rsp_dz_o       (rsp_dz),
        .rsp_ovf_o      (rsp_ovf),
        .rsp_ill_o      (rsp_ill)
    );

    // bf16 via IEEE double; subnormals flush to zero, results truncate.
    function automatic real bf2r(input logic [15:0] v);
        logic [10:0] e11;
        logic [63:0] b;
        if (v[14:7] == 8'd0) return 0.0;
        e11 = {3'b000, v[14:7]} + 11'd896;
        b = {v[15], e11, v[6:0], 45'd0};
        return $bitstoreal(b);
    endfunction

    function automatic logic [16:0] r2bf(input real r);
        logic [63:0] b;
        int e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 15'd0, 1'b0};
        e = int'(b[62:52]) - 896;
        if (e >= 255) return {b[63], 8'hFF, 7'd0, 1'b1};
        if (e <= 0) return {b[63], 15'd0, 1'b0};
        return {b[63], e[7:0], b[51:45], 1'b0};
    endfunction

    // Returns {data, dz, ovf}; junk with both flags for non-fpu opcodes.
    function automatic logic [17:0] fpu_model(input logic [3:0] op,
                                              input logic [15:0] a,
                                              input logic [15:0] b);
        real x, y;
        logic [16:0] t;
        x = bf2r(a);
        y = bf2r(b);
        case (op)
            4'd0: t = r2bf(x + y);
            4'd1: t = r2bf(x - y);
            4'd2: t = r2bf(x * y);
            4'd3: begin
                if (y == 0.0) return {a[15] ^ b[15], 8'hFF, 7'd0, 2'b10};
                t = r2bf(x / y);
            end
            default: return {a, 2'b11};
        endcase
        return {t[16:1], 1'b0, t[0]};
    endfunction

    always_comb begin
        {fpu_out, fpu_dz, fpu_ovf} = fpu_model(fpu_op, fpu_in1, fpu_in2);
    end

    function automatic exp_t ref_rsp(input logic [3:0] op, input logic [15:0] a,
                                     input logic [15:0] b, input logic [TAG_W-1:0] tag);
        exp_t e;
        logic [17:0] m;
        if (op > 4'd3) begin
            e = '{data: 16'h7FC0, tag: tag, dz: 1'b0, ovf: 1'b0, ill: 1'b1};
        end else begin
            m = fpu_model(op, a, b);
            e = '{data: m[17:2], tag: tag, dz: m[1], ovf: m[0], ill: 1'b0};
        end
        return e;
    endfunction

    function automatic logic [15:0] rand_bf();
        logic [7:0] e;
        e = 8'($urandom_range(120, 134));
        return {1'($urandom), e, 7'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [TAG_W-1:0] tag);
        tick();
        req_valid = 1'b1;
        req_op = op;
        req_in1 = a;
        req_in2 = b;
        req_tag = tag;
        tick();
        req_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid);
        else n_pass++;
        n_checks++;
        if ({fpu_op, fpu_in1, fpu_in2} !== 36'd0)
            $display("FAIL reset_fpu_outs got %h exp 0", {fpu_op, fpu_in1, fpu_in2});
        else n_pass++;
        n_checks++;
        if ({rsp_data, rsp_tag, rsp_dz, rsp_ovf, rsp_ill} !== '0)
            $display("FAIL reset_rsp_fields got %h exp 0", {rsp_data, rsp_tag, rsp_dz, rsp_ovf, rsp_ill});
        else n_pass++;
`ifdef FPU_STICKY_FLAGS_EN
        n_checks++;
        if ({sticky_dz, sticky_ovf} !== 2'b00)
            $display("FAIL reset_sticky got %b exp 00", {sticky_dz, sticky_ovf});
        else n_pass++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_add();
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b1;
        req_op = 4'd0;
        req_in1 = 16'h3F80;
        req_in2 = 16'h4000;
        req_tag = 4'd1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL add_req_ready got %b exp 1", req_ready);
        else n_pass++;
        tick();
        req_valid = 1'b0;
        n_checks++;
        if ({fpu_op, fpu_in1, fpu_in2, rsp_valid} !== {4'd0, 16'h3F80, 16'h4000, 1'b0})
            $display("FAIL add_exec got %h exp %h", {fpu_op, fpu_in1, fpu_in2, rsp_valid},
                     {4'd0, 16'h3F80, 16'h4000, 1'b0});
        else n_pass++;
        tick();
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_tag, rsp_dz, rsp_ovf, rsp_ill} !== {1'b1, 16'h4040, 4'd1, 3'b000})
            $display("FAIL add_rsp got %h exp %h", {rsp_valid, rsp_data, rsp_tag, rsp_dz, rsp_ovf, rsp_ill},
                     {1'b1, 16'h4040, 4'd1, 3'b000});
        else n_pass++;
        n_checks++;
        if (fpu_in1 !== 16'h0) $display("FAIL add_exec_clear got %h exp 0", fpu_in1);
        else n_pass++;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) $display("FAIL add_pop got %b exp 0", rsp_valid);
        else n_pass++;
    endtask

    task automatic test_div();
        rsp_ready = 1'b1;
        send_one(4'd3, 16'h3F80, 16'h0000, 4'd2);
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_tag, rsp_dz, rsp_ovf, rsp_ill} !== {1'b1, 16'h7F80, 4'd2, 3'b100})
            $display("FAIL div_rsp got %h exp %h", {rsp_valid, rsp_data, rsp_tag, rsp_dz, rsp_ovf, rsp_ill},
                     {1'b1, 16'h7F80, 4'd2, 3'b100});
        else n_pass++;
`ifdef FPU_STICKY_FLAGS_EN
        tick();
        tick();
        n_checks++;
        if (sticky_dz !== 1'b1) $display("FAIL div_sticky_hold got %b exp 1", sticky_dz);
        else n_pass++;
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        n_checks++;
        if (sticky_dz !== 1'b0) $display("FAIL div_sticky_clear got %b exp 0", sticky_dz);
        else n_pass++;
`endif
        tick();
    endtask

    task automatic test_mul();
        rsp_ready = 1'b1;
        send_one(4'd2, 16'h7F7F, 16'h4000, 4'd3);
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_tag, rsp_dz, rsp_ovf, rsp_ill} !== {1'b1, 16'h7F80, 4'd3, 3'b010})
            $display("FAIL mul_rsp got %h exp %h", {rsp_valid, rsp_data, rsp_tag, rsp_dz, rsp_ovf, rsp_ill},
                     {1'b1, 16'h7F80, 4'd3, 3'b010});
        else n_pass++;
`ifdef FPU_STICKY_FLAGS_EN
        n_checks++;
        if (sticky_ovf !== 1'b1) $display("FAIL mul_sticky_set got %b exp 1", sticky_ovf);
        else n_pass++;
        req_valid = 1'b1;
        req_op = 4'd2;
        req_in1 = 16'h7F7F;
        req_in2 = 16'h4000;
        req_tag = 4'd4;
        tick();
        req_valid = 1'b0;
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        n_checks++;
        if ({sticky_ovf, rsp_ovf} !== 2'b11)
            $display("FAIL mul_set_wins got %b exp 11", {sticky_ovf, rsp_ovf});
        else n_pass++;
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        n_checks++;
        if (sticky_ovf !== 1'b0) $display("FAIL mul_sticky_clear got %b exp 0", sticky_ovf);
        else n_pass++;
`endif
        tick();
    endtask

    task automatic test_illegal();
        rsp_ready = 1'b1;
        send_one(4'hF, rand_bf(), rand_bf(), 4'd5);
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_tag, rsp_dz, rsp_ovf, rsp_ill} !== {1'b1, 16'h7FC0, 4'd5, 3'b001})
            $display("FAIL illegal_rsp got %h exp %h", {rsp_valid, rsp_data, rsp_tag, rsp_dz, rsp_ovf, rsp_ill},
                     {1'b1, 16'h7FC0, 4'd5, 3'b001});
        else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        exp_t ex[6];
        int idx = 0;
        int got = 0;
        for (int i = 0; i < 6; i++) begin
            ex[i] = ref_rsp(4'd0, rand_bf(), rand_bf(), TAG_W'(i));
            ex[i].data = 16'h0;
        end
        for (int i = 0; i < 6; i++) begin
            logic [15:0] a, b;
            a = rand_bf();
            b = rand_bf();
            ex[i] = ref_rsp(4'(i % 4), a, b, TAG_W'(i));
            ex[i].dz = 1'b0;
            ex[i].data = {a[15:8], b[7:0]};
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            rsp_ready = (cyc >= 10);
            req_valid = (idx < 6);
            if (idx < 6) begin
                req_op = 4'(idx % 4);
                req_in1 = {ex[idx].data[15:8], 8'h00};
                req_in2 = {8'h00, ex[idx].data[7:0]};
                req_tag = TAG_W'(idx);
            end
            #1;
            if (cyc == 9) begin
                n_checks++;
                if (idx != DEPTH + 1) $display("FAIL bp_accepted got %0d exp %0d", idx, DEPTH + 1);
                else n_pass++;
                n_checks++;
                if ({req_ready, rsp_valid} !== 2'b01)
                    $display("FAIL bp_stall got %b exp 01", {req_ready, rsp_valid});
                else n_pass++;
            end
            if (rsp_valid && rsp_ready) begin
                n_checks++;
                if (got >= 6 || rsp_tag !== TAG_W'(got))
                    $display("FAIL bp_order got tag %0d exp %0d", rsp_tag, got);
                else n_pass++;
                got++;
            end
            if (req_valid && req_ready) idx++;
        end
        n_checks++;
        if (got != 6) $display("FAIL bp_drained got %0d exp 6", got);
        else n_pass++;
    endtask

    task automatic test_random();
        exp_t e;
        logic acc_last = 1'b0;
        logic ev;
        int cnt;
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            req_valid = ($urandom_range(0, 3) != 0) && (cyc < 560);
            rsp_ready = (cyc >= 560) || ($urandom_range(0, 2) != 0);
            req_op = 4'($urandom_range(0, 5));
            req_in1 = rand_bf();
            req_in2 = ($urandom_range(0, 7) == 0) ? 16'h0 : rand_bf();
            req_tag = TAG_W'($urandom);
            #1;
            ev = acc_last || (q.size() == DEPTH + 1);
            cnt = q.size() - int'(ev);
            n_checks++;
            if (req_ready !== ((q.size() <= DEPTH) || rsp_ready))
                $display("FAIL rnd_req_ready cyc %0d got %b inflight %0d", cyc, req_ready, q.size());
            else n_pass++;
            n_checks++;
            if (rsp_valid !== (cnt > 0))
                $display("FAIL rnd_rsp_valid cyc %0d got %b exp %b", cyc, rsp_valid, cnt > 0);
            else n_pass++;
            if (rsp_valid && rsp_ready && q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if ({rsp_data, rsp_tag, rsp_dz, rsp_ovf, rsp_ill} !== e)
                    $display("FAIL rnd_rsp cyc %0d got %h exp %h", cyc,
                             {rsp_data, rsp_tag, rsp_dz, rsp_ovf, rsp_ill}, e);
                else n_pass++;
            end
            acc_last = req_valid && req_ready;
            if (acc_last) q.push_back(ref_rsp(req_op, req_in1, req_in2, req_tag));
        end
        req_valid = 1'b0;
        n_checks++;
        if (q.size() != 0) $display("FAIL rnd_leftover got %0d exp 0", q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        tick();
        req_valid = 1'b1;
        req_op = 4'd0;
        req_in1 = 16'h3F80;
        req_in2 = 16'h3F80;
        tick();
        tick();
        req_valid = 1'b0;
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1) $display("FAIL mid_prefill got %b exp 1", rsp_valid);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, req_ready, fpu_in1} !== {2'b01, 16'h0})
            $display("FAIL mid_async got %h exp %h", {rsp_valid, req_ready, fpu_in1}, {2'b01, 16'h0});
        else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01)
            $display("FAIL mid_release got %b exp 01", {rsp_valid, req_ready});
        else n_pass++;
        rsp_ready = 1'b1;
        send_one(4'd0, 16'h3F80, 16'h4000, 4'd9);
        n_checks++;
        if ({rsp_valid, rsp_data, rsp_tag} !== {1'b1, 16'h4040, 4'd9})
            $display("FAIL mid_recover got %h exp %h", {rsp_valid, rsp_data, rsp_tag}, {1'b1, 16'h4040, 4'd9});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_div();
        test_mul();
        test_illegal();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
